vecgate_rr_scheduler: RTL



---
 rtl/vecgate_pkg.sv | 40 ++++
 rtl/vecgate_alu.sv | 20 ++
 rtl/vecgate_rr_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/vecgate_pkg.sv
// Shared types and the result function for the vector-gate scheduler.
// Widths up to MAX_W are supported by calc_result.
package vecgate_pkg;

   typedef enum logic [1:0] {
      OP_OR_BIT  = 2'd0,
      OP_OR_LOG  = 2'd1,
      OP_AND_BIT = 2'd2,
      OP_NOT_CAT = 2'd3
   } op_e;

   localparam int unsigned DEF_W     = 3;
   localparam int unsigned DEF_RES_W = 2 * DEF_W;
   localparam int unsigned MAX_W     = 32;

   // Operands arrive zero-extended to MAX_W; w is the real operand width.
   function automatic logic [2*MAX_W-1:0] calc_result(input op_e op,
                                                      input logic [MAX_W-1:0] a,
                                                      input logic [MAX_W-1:0] b,
                                                      input int unsigned w);
      logic [2*MAX_W-1:0] r;
      r = '0;
      unique case (op)
         OP_OR_BIT:  r[MAX_W-1:0] = a | b;
         OP_OR_LOG:  r[0] = |(a | b);
         OP_AND_BIT: r[MAX_W-1:0] = a & b;
         OP_NOT_CAT: begin
            for (int unsigned i = 0; i < MAX_W; i++) begin
               if (i < w) begin
                  r[i]     = ~a[i];
                  r[i + w] = ~b[i];
               end
            end
         end
         default:    r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vecgate_alu.sv
// Combinational vector-gate unit: (op, a, b) -> zero-extended 2W-bit result.
module vecgate_alu
   import vecgate_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  op_e            op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] result
);

   logic [2*MAX_W-1:0] full;

   always_comb begin
      full   = calc_result(op, MAX_W'(a), MAX_W'(b), W);
      result = full[2*W-1:0];
   end

endmodule

// File: rtl/vecgate_rr_scheduler.sv
// Round-robin scheduler sharing one vector-gate unit between N_REQ requesters,
// with a single registered, backpressured response slot.
module vecgate_rr_scheduler
   import vecgate_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   parameter  int unsigned W     = DEF_W,
   localparam int unsigned IDW   = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [2*N_REQ-1:0]   req_op,
   input  logic [W*N_REQ-1:0]   req_a,
   input  logic [W*N_REQ-1:0]   req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [1:0]           rsp_op,
   output logic [2*W-1:0]       rsp_data
);

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_nxt;
   logic [IDW-1:0]   idx;
   logic [IDW-1:0]   grant_id;
   logic [N_REQ-1:0] grant;
   logic             found;
   logic             slot_free;

   op_e              sel_op;
   logic [W-1:0]     sel_a;
   logic [W-1:0]     sel_b;
   logic [2*W-1:0]   alu_res;

   assign slot_free = !rsp_valid || rsp_ready;

   // Rotating priority search starting at ptr; the grant never looks at command data.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      if (slot_free) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IDW'((32'(ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               grant_id   = idx;
            end
         end
      end
   end

   assign req_ready = grant;
   assign ptr_nxt   = IDW'((32'(grant_id) + 1) % N_REQ);

   // AND-OR mux keyed on the one-hot grant so unselected inputs cannot leak.
   always_comb begin
      sel_op = OP_OR_BIT;
      sel_a  = '0;
      sel_b  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_op = op_e'(req_op[2*i +: 2]);
            sel_a  = req_a[W*i +: W];
            sel_b  = req_b[W*i +: W];
         end
      end
   end

   vecgate_alu #(
      .W (W)
   ) u_alu (
      .op     (sel_op),
      .a      (sel_a),
      .b      (sel_b),
      .result (alu_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_op    <= '0;
         rsp_data  <= '0;
         ptr       <= '0;
      end else if (found) begin
         rsp_valid <= 1'b1;
         rsp_id    <= grant_id;
         rsp_op    <= sel_op;
         rsp_data  <= alu_res;
         ptr       <= ptr_nxt;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
